// File: rtl/sa_arb_pkg.sv
// rtl/sa_arb_pkg.sv - shared types and constants for the systolic-array arbiter
package sa_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 4096;

    function automatic int grant_w(input int n_req);
        return $clog2(n_req);
    endfunction

    function automatic int wd_w(input int timeout_cyc);
        return $clog2(timeout_cyc);
    endfunction

    localparam int         GRANT_W   = grant_w(N_REQ_DEF);
    localparam int         WD_W      = wd_w(TIMEOUT_DEF);
    localparam logic [7:0] M_DIM_RST = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_BUSY  = 3'b100
    } sa_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first pending at or after ptr
module rr_arbiter
    import sa_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int GW    = grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0] pend_i,
    input  logic [GW-1:0]    ptr_i,
    output logic [GW-1:0]    grant_o,
    output logic             found_o
);

    localparam int SW = GW + 1;

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SW-1:0]      sum;

    // Rotate so bit 0 is the requester at ptr; scan downwards so the lowest offset wins.
    always_comb begin
        dbl     = {pend_i, pend_i};
        rot     = N_REQ'(dbl >> ptr_i);
        grant_o = '0;
        found_o = 1'b0;
        sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr_i} + SW'(k);
                if (sum >= SW'(N_REQ)) begin
                    sum = sum - SW'(N_REQ);
                end
                grant_o = sum[GW-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_arbiter.sv
// rtl/sa_arbiter.sv - shares one systolic-array wrapper between N_REQ requesters
module sa_arbiter
    import sa_arb_pkg::*;
#(
    parameter  int D_W         = 8,
    parameter  int SA_R        = 16,
    parameter  int SA_C        = 16,
    parameter  int MAT_K       = 128,
    parameter  int N_REQ       = N_REQ_DEF,
    parameter  int TIMEOUT_CYC = TIMEOUT_DEF,
    localparam int GW          = grant_w(N_REQ),
    localparam int WW          = wd_w(TIMEOUT_CYC)
) (
    input  logic                                         I_CLK,
    input  logic                                         I_ASYN_RSTN,
    input  logic [N_REQ-1:0]                             I_REQ_START,
    input  logic [N_REQ-1:0][SA_R-1:0][MAT_K-1:0][D_W-1:0] I_REQ_MAT_1,
    input  logic [N_REQ-1:0][MAT_K-1:0][SA_C-1:0][D_W-1:0] I_REQ_MAT_2,
    input  logic [N_REQ-1:0][7:0]                        I_REQ_M_DIM,
    output logic [N_REQ-1:0]                             O_REQ_VLD,
    output logic [N_REQ-1:0]                             O_REQ_ERR,
    output logic [N_REQ-1:0]                             O_REQ_PE_SHIFT,
    output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]           O_REQ_RESULT,
    output logic                                         O_SA_START,
    output logic [SA_R-1:0][MAT_K-1:0][D_W-1:0]          O_SA_MAT_1,
    output logic [MAT_K-1:0][SA_C-1:0][D_W-1:0]          O_SA_MAT_2,
    output logic [7:0]                                   O_SA_M_DIM,
    input  logic                                         I_SA_VLD,
    input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]           I_SA_RESULT,
    input  logic                                         I_PE_SHIFT,
    output logic                                         O_BUSY,
    output logic [GW-1:0]                                O_GRANT_ID,
    output logic                                         O_DUP_START,
    output logic                                         O_TIMEOUT
);

    sa_state_e          state_q, state_d;
    logic [N_REQ-1:0]   pend_q, pend_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      gid_q, gid_d;
    logic [WW-1:0]      wd_q, wd_d;
    logic [N_REQ-1:0]   vld_q, vld_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic               dup_q, dup_d;
    logic               tmo_q, tmo_d;
    logic [N_REQ-1:0]   done_mask;
    logic               load_ops, load_res;
    logic [GW-1:0]      arb_g;
    logic               arb_found;

    logic [SA_R-1:0][MAT_K-1:0][D_W-1:0] mat1_q;
    logic [MAT_K-1:0][SA_C-1:0][D_W-1:0] mat2_q;
    logic [7:0]                          mdim_q;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]  res_q;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .grant_o (arb_g),
        .found_o (arb_found)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        wd_d      = wd_q;
        vld_d     = '0;
        err_d     = '0;
        tmo_d     = tmo_q;
        dup_d     = dup_q;
        done_mask = '0;
        load_ops  = 1'b0;
        load_res  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    load_ops = 1'b1;
                    gid_d    = arb_g;
                    ptr_d    = (arb_g == GW'(N_REQ - 1)) ? '0 : arb_g + 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                wd_d = wd_q + 1'b1;
                if (I_SA_VLD) begin
                    load_res         = 1'b1;
                    vld_d[gid_q]     = 1'b1;
                    done_mask[gid_q] = 1'b1;
                    state_d          = ST_IDLE;
                end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
                    err_d[gid_q]     = 1'b1;
                    tmo_d            = 1'b1;
                    done_mask[gid_q] = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A start landing on its own completion edge re-arms rather than counting as a duplicate.
        pend_d = pend_q & ~done_mask;
        for (int i = 0; i < N_REQ; i++) begin
            if (I_REQ_START[i]) begin
                if (pend_q[i] && !done_mask[i]) begin
                    dup_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            wd_q    <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            dup_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            wd_q    <= wd_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            dup_q   <= dup_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            mat1_q <= '0;
            mat2_q <= '0;
            mdim_q <= M_DIM_RST;
            res_q  <= '0;
        end else begin
            if (load_ops) begin
                mat1_q <= I_REQ_MAT_1[arb_g];
                mat2_q <= I_REQ_MAT_2[arb_g];
                mdim_q <= I_REQ_M_DIM[arb_g];
            end
            if (load_res) begin
                res_q <= I_SA_RESULT;
            end
        end
    end

    always_comb begin
        O_REQ_PE_SHIFT = '0;
        if (state_q != ST_IDLE) begin
            O_REQ_PE_SHIFT[gid_q] = I_PE_SHIFT;
        end
    end

    assign O_SA_START   = (state_q == ST_ISSUE);
    assign O_BUSY       = (state_q != ST_IDLE);
    assign O_GRANT_ID   = gid_q;
    assign O_REQ_VLD    = vld_q;
    assign O_REQ_ERR    = err_q;
    assign O_REQ_RESULT = res_q;
    assign O_SA_MAT_1   = mat1_q;
    assign O_SA_MAT_2   = mat2_q;
    assign O_SA_M_DIM   = mdim_q;
    assign O_DUP_START  = dup_q;
    assign O_TIMEOUT    = tmo_q;

endmodule

// File: tb/tb_sa_arbiter.sv
// tb/tb_sa_arbiter.sv - self-checking bench for sa_arbiter
module tb_sa_arbiter;
    import sa_arb_pkg::*;

    localparam int D_W = 8, SA_R = 2, SA_C = 2, MAT_K = 4, N = 4;
    localparam int RW  = SA_R * SA_C * D_W;
    localparam int NV  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] start = '0;
    logic [N-1:0][SA_R-1:0][MAT_K-1:0][D_W-1:0] mat1;
    logic [N-1:0][MAT_K-1:0][SA_C-1:0][D_W-1:0] mat2;
    logic [N-1:0][7:0] mdim;
    logic sa_vld = 1'b0, pe = 1'b0;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0] sa_res = '0;

    logic [N-1:0] o_vld, o_err, o_pe;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0] o_res;
    logic sa_start, busy, dup, tmo;
    logic [SA_R-1:0][MAT_K-1:0][D_W-1:0] sa_m1;
    logic [MAT_K-1:0][SA_C-1:0][D_W-1:0] sa_m2;
    logic [7:0] sa_mdim;
    logic [GRANT_W-1:0] gid;

    logic wd_sa_vld = 1'b0;
    logic [N-1:0] wd_vld, wd_err, wd_pe;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0] wd_res;
    logic wd_sa_start, wd_busy, wd_dup, wd_tmo;
    logic [SA_R-1:0][MAT_K-1:0][D_W-1:0] wd_m1;
    logic [MAT_K-1:0][SA_C-1:0][D_W-1:0] wd_m2;
    logic [7:0] wd_mdim;
    logic [GRANT_W-1:0] wd_gid;

    sa_arbiter #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .MAT_K(MAT_K), .N_REQ(N)) dut (
        .I_CLK(clk), .I_ASYN_RSTN(rst_n), .I_REQ_START(start),
        .I_REQ_MAT_1(mat1), .I_REQ_MAT_2(mat2), .I_REQ_M_DIM(mdim),
        .O_REQ_VLD(o_vld), .O_REQ_ERR(o_err), .O_REQ_PE_SHIFT(o_pe), .O_REQ_RESULT(o_res),
        .O_SA_START(sa_start), .O_SA_MAT_1(sa_m1), .O_SA_MAT_2(sa_m2), .O_SA_M_DIM(sa_mdim),
        .I_SA_VLD(sa_vld), .I_SA_RESULT(sa_res), .I_PE_SHIFT(pe),
        .O_BUSY(busy), .O_GRANT_ID(gid), .O_DUP_START(dup), .O_TIMEOUT(tmo)
    );

    sa_arbiter #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .MAT_K(MAT_K), .N_REQ(N), .TIMEOUT_CYC(16)) dut_wd (
        .I_CLK(clk), .I_ASYN_RSTN(rst_n), .I_REQ_START(start),
        .I_REQ_MAT_1(mat1), .I_REQ_MAT_2(mat2), .I_REQ_M_DIM(mdim),
        .O_REQ_VLD(wd_vld), .O_REQ_ERR(wd_err), .O_REQ_PE_SHIFT(wd_pe), .O_REQ_RESULT(wd_res),
        .O_SA_START(wd_sa_start), .O_SA_MAT_1(wd_m1), .O_SA_MAT_2(wd_m2), .O_SA_M_DIM(wd_mdim),
        .I_SA_VLD(wd_sa_vld), .I_SA_RESULT(sa_res), .I_PE_SHIFT(pe),
        .O_BUSY(wd_busy), .O_GRANT_ID(wd_gid), .O_DUP_START(wd_dup), .O_TIMEOUT(wd_tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    typedef struct packed {
        logic [N-1:0]  oh;
        logic [RW-1:0] res;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n && o_vld != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_vld", 64'(o_vld), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("sb_vld_onehot", 64'(o_vld), 64'(mon_e.oh));
                chk("sb_result", 64'(o_res), 64'(mon_e.res));
            end
        end
    end

    typedef struct {
        logic [N-1:0]       start;
        int                 lat;
        logic [7:0]         res;
        logic [GRANT_W-1:0] exp_g;
    } vec_t;
    vec_t vt[NV];

    task automatic do_reset();
        start  = '0;
        sa_vld = 1'b0;
        pe     = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(output int sc, output logic [GRANT_W-1:0] g);
        sc = -1;
        g  = '0;
        for (int k = 0; k < 50 && !sa_start; k++) @(negedge clk);
        if (!sa_start) begin
            fail_to("sa_start");
        end else begin
            sc = cyc;
            g  = gid;
        end
    endtask

    task automatic finish_job(input int lat, input logic [7:0] r, input logic [N-1:0] restart,
                              input logic [GRANT_W-1:0] g, output int vc);
        repeat (lat) @(negedge clk);
        sa_vld = 1'b1;
        sa_res = {SA_R*SA_C{r}};
        sb.push_back('{oh: N'(1) << g, res: {SA_R*SA_C{r}}});
        vc = cyc;
        @(negedge clk);
        sa_vld = 1'b0;
        start  = restart;
        chk("vld_latency", 64'(o_vld), 64'(N'(1) << g));
        @(negedge clk);
        start = '0;
    endtask

    int s, sc, vc, vc_prev, wsc, ec;
    logic [GRANT_W-1:0] g;
    logic [GRANT_W-1:0] fair_exp [5];

    initial begin
        for (int r = 0; r < N; r++) begin
            mat1[r] = {$urandom, $urandom};
            mat2[r] = {$urandom, $urandom};
            mdim[r] = 8'(3 + r);
        end
        vt[0] = '{start: 4'b0010, lat: 20, res: 8'h11, exp_g: 2'd1};
        vt[1] = '{start: 4'b0001, lat: 3,  res: 8'hA5, exp_g: 2'd0};
        vt[2] = '{start: 4'b1000, lat: 1,  res: 8'h3C, exp_g: 2'd3};
        vt[3] = '{start: 4'b0100, lat: 5,  res: 8'h5A, exp_g: 2'd2};
        fair_exp = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};

        do_reset();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sa_start", 64'(sa_start), 64'(0));
        chk("rst_gid", 64'(gid), 64'(0));
        chk("rst_mat1", 64'(sa_m1), 64'(0));
        chk("rst_mat2", 64'(sa_m2), 64'(0));
        chk("rst_mdim", 64'(sa_mdim), 64'(128));
        chk("rst_vld", 64'(o_vld), 64'(0));
        chk("rst_err", 64'(o_err), 64'(0));
        chk("rst_res", 64'(o_res), 64'(0));
        chk("rst_pe", 64'(o_pe), 64'(0));
        chk("rst_dup", 64'(dup), 64'(0));
        chk("rst_tmo", 64'(tmo), 64'(0));

        for (int i = 0; i < NV; i++) begin
            start = vt[i].start;
            s = cyc;
            @(negedge clk);
            start = '0;
            wait_start(sc, g);
            chk("tbl_grant", 64'(g), 64'(vt[i].exp_g));
            chk("tbl_start_latency", 64'(sc - s), 64'(2));
            chk("tbl_mat1", 64'(sa_m1), 64'(mat1[vt[i].exp_g]));
            chk("tbl_mat2", 64'(sa_m2), 64'(mat2[vt[i].exp_g]));
            chk("tbl_mdim", 64'(sa_mdim), 64'(mdim[vt[i].exp_g]));
            chk("tbl_busy", 64'(busy), 64'(1));
            finish_job(vt[i].lat, vt[i].res, '0, g, vc);
            chk("tbl_idle_after", 64'(busy), 64'(0));
            chk("tbl_mat1_hold", 64'(sa_m1), 64'(mat1[vt[i].exp_g]));
        end

        do_reset();
        start = 4'b1111;
        @(negedge clk);
        start = '0;
        vc_prev = 0;
        for (int k = 0; k < N; k++) begin
            wait_start(sc, g);
            chk("all_grant_order", 64'(g), 64'(k));
            if (k > 0) chk("all_gap", 64'(sc - vc_prev), 64'(2));
            finish_job(2, 8'(8'h20 + k), '0, g, vc);
            vc_prev = vc;
        end
        chk("all_idle_after", 64'(busy), 64'(0));

        do_reset();
        start = 4'b0101;
        @(negedge clk);
        start = '0;
        for (int k = 0; k < 5; k++) begin
            wait_start(sc, g);
            chk("fair_grant", 64'(g), 64'(fair_exp[k]));
            finish_job(2, 8'(8'h40 + k), (k < 3) ? (N'(1) << g) : '0, g, vc);
        end
        chk("fair_no_dup", 64'(dup), 64'(0));
        chk("fair_idle_after", 64'(busy), 64'(0));

        do_reset();
        start = 4'b1000;
        @(negedge clk);
        start = '0;
        wait_start(sc, g);
        chk("pe_grant", 64'(g), 64'(3));
        for (int k = 0; k < 6; k++) begin
            pe = ~k[0];
            #1;
            chk("pe_route", 64'(o_pe), 64'(pe ? 4'b1000 : 4'b0000));
            @(negedge clk);
        end
        pe = 1'b0;
        finish_job(1, 8'h77, '0, g, vc);
        pe = 1'b1;
        #1;
        chk("pe_idle_zero", 64'(o_pe), 64'(0));
        pe = 1'b0;

        do_reset();
        start = 4'b0011;
        @(negedge clk);
        start = '0;
        for (int k = 0; k < 50 && !wd_sa_start; k++) @(negedge clk);
        if (!wd_sa_start) fail_to("wd_sa_start");
        wsc = cyc;
        chk("wd_grant0", 64'(wd_gid), 64'(0));
        chk("wd_tmo_before", 64'(wd_tmo), 64'(0));
        for (int k = 0; k < 40 && wd_err == '0; k++) @(negedge clk);
        if (wd_err == '0) fail_to("wd_err");
        ec = cyc;
        chk("wd_err_cycle", 64'(ec - wsc), 64'(17));
        chk("wd_err_onehot", 64'(wd_err), 64'(4'b0001));
        chk("wd_no_vld", 64'(wd_vld), 64'(0));
        chk("wd_tmo_sticky", 64'(wd_tmo), 64'(1));
        @(negedge clk);
        chk("wd_err_pulse", 64'(wd_err), 64'(0));
        for (int k = 0; k < 10 && !wd_sa_start; k++) @(negedge clk);
        chk("wd_next_start", 64'(wd_sa_start), 64'(1));
        chk("wd_next_grant", 64'(wd_gid), 64'(1));

        do_reset();
        start = 4'b0100;
        @(negedge clk);
        start = '0;
        wait_start(sc, g);
        chk("dup_grant", 64'(g), 64'(2));
        @(negedge clk);
        start = 4'b0100;
        @(negedge clk);
        start = '0;
        chk("dup_sticky", 64'(dup), 64'(1));
        chk("dup_busy", 64'(busy), 64'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_dup", 64'(dup), 64'(0));
        chk("mid_rst_gid", 64'(gid), 64'(0));
        chk("mid_rst_mat1", 64'(sa_m1), 64'(0));
        chk("mid_rst_mdim", 64'(sa_mdim), 64'(128));
        chk("mid_rst_res", 64'(o_res), 64'(0));
        chk("mid_rst_vld", 64'(o_vld), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sa_vld = 1'b1;
        @(negedge clk);
        sa_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 64'(busy), 64'(0));
        start = 4'b0100;
        @(negedge clk);
        start = '0;
        wait_start(sc, g);
        chk("post_rst_grant", 64'(g), 64'(2));
        finish_job(4, 8'hC3, '0, g, vc);
        chk("post_rst_no_dup", 64'(dup), 64'(0));

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sa_arbiter.md
Name: sa_arbiter

Overview:
Shares one systolic-array wrapper between N_REQ attention-head controllers, each of which issues single-cycle start pulses with its matrices held stable until it sees its valid.
- Latches per-requester pending starts and grants the SA round-robin.
- Registers the granted operands and M-dim into the SA, then routes SA valid, result and PE-shift back to the granted requester only.
- Provides a per-job watchdog and sticky protocol-error flags.

Parameters:
D_W, 8, data word width
SA_R, 16, SA rows
SA_C, 16, SA columns
MAT_K, 128, inner (reduction) dimension of the operand matrices
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 4096, max BUSY cycles before job abort

Ports:
I_CLK  in  1  clock
I_ASYN_RSTN  in  1  asynchronous active-low reset
I_REQ_START  in  N_REQ  per-requester start pulse
I_REQ_MAT_1  in  [N_REQ][SA_R][MAT_K]xD_W  left operands, held stable until own O_REQ_VLD
I_REQ_MAT_2  in  [N_REQ][MAT_K][SA_C]xD_W  right operands, held stable until own O_REQ_VLD
I_REQ_M_DIM  in  [N_REQ]x8  valid inner length per request
O_REQ_VLD  out  N_REQ  one-hot result-valid pulse
O_REQ_ERR  out  N_REQ  one-hot pulse, job aborted by watchdog
O_REQ_PE_SHIFT  out  N_REQ  I_PE_SHIFT routed to granted requester
O_REQ_RESULT  out  [SA_R][SA_C]xD_W  registered result, shared by all requesters
O_SA_START  out  1  start pulse to SA wrapper
O_SA_MAT_1  out  [SA_R][MAT_K]xD_W  to SA
O_SA_MAT_2  out  [MAT_K][SA_C]xD_W  to SA
O_SA_M_DIM  out  8  to SA
I_SA_VLD  in  1  SA result valid
I_SA_RESULT  in  [SA_R][SA_C]xD_W  SA result
I_PE_SHIFT  in  1  SA PE-shift indicator
O_BUSY  out  1  high in ISSUE/BUSY
O_GRANT_ID  out  $clog2(N_REQ)  current/last grant index
O_DUP_START  out  1  sticky: start seen while that requester was already pending/granted
O_TIMEOUT  out  1  sticky: any watchdog abort

Behaviour:
- Reset values: all outputs 0, matrices 0, O_SA_M_DIM=128, state IDLE. Round-robin pointer=0, pending=0, watchdog=0.
- Reset mid-job: pending and the in-flight job are dropped; no VLD or ERR is emitted for them.
- pending[i] is set on the edge that samples I_REQ_START[i]=1 and cleared when job i completes or aborts.
  - Set wins over clear in the same cycle.
  - A start while pending[i]=1 or i is granted sets O_DUP_START and is otherwise ignored.
- States: IDLE, ISSUE, BUSY.
- IDLE: if any pending, grant g = first pending at or after ptr (wrapping).
  - Register O_SA_MAT_1/2 and O_SA_M_DIM from requester g; O_GRANT_ID<=g; ptr<=g+1 mod N_REQ; go to ISSUE.
  - Otherwise stay; SA operand registers hold.
- ISSUE: O_SA_START=1 for exactly this cycle; watchdog cleared; go to BUSY.
- BUSY:
  - Watchdog increments each cycle.
  - On I_SA_VLD: O_REQ_RESULT<=I_SA_RESULT; O_REQ_VLD[g]=1 for 1 cycle; clear pending[g]; go to IDLE.
  - Else if watchdog==TIMEOUT_CYC-1: O_REQ_ERR[g] pulse; O_TIMEOUT set; clear pending[g]; go to IDLE.
  - I_SA_VLD wins over timeout in the same cycle.
  - I_SA_VLD outside BUSY is ignored.
- Latency:
  - Start sampled at edge E0 with arbiter IDLE: O_SA_START is high in the cycle after E1.
  - I_SA_VLD sampled at edge En: O_REQ_VLD[g] is high in the cycle after En.
  - Back-to-back jobs have a 2-cycle gap (IDLE, ISSUE) between VLD and the next O_SA_START.
- O_REQ_PE_SHIFT[g]=I_PE_SHIFT combinationally while in ISSUE/BUSY; all bits 0 otherwise.
- Matrix outputs change only on the IDLE->ISSUE edge.
- O_SA_M_DIM is passed unchanged, with no range check.

Decomposition:
- Package sa_arb_pkg holds:
  - state enum (one-hot, 3 bits);
  - GRANT_W = $clog2(N_REQ);
  - M_DIM reset constant 8'd128;
  - watchdog width $clog2(TIMEOUT_CYC).
- Sub-module rr_arbiter: pending vector + ptr in, grant index + found flag out (combinational). Pointer register lives in sa_arbiter.

Test Plan:
- Single requester: start[1] pulse, SA VLD 20 cycles after O_SA_START with result all 8'h11 -> O_GRANT_ID=1, O_SA_MAT_1 equals req 1 operands, O_REQ_VLD=4'b0010 for 1 cycle, O_REQ_RESULT=8'h11.
- Simultaneous starts 4'b1111 after reset -> grant order 0,1,2,3, one VLD each, 2-cycle gap between jobs.
- Fairness: req 0 restarts immediately after each VLD while req 2 is pending -> grants alternate 0,2,0,2; req 0 never takes two grants in a row.
- PE_SHIFT routing: I_PE_SHIFT toggling during req 3 job -> only O_REQ_PE_SHIFT[3] follows; all bits 0 in IDLE.
- Watchdog: TIMEOUT_CYC=16 and no I_SA_VLD -> O_REQ_ERR[g] pulse 16 cycles after ISSUE, O_TIMEOUT=1, next pending request granted.
- Duplicate start on req 2 during its BUSY, then I_ASYN_RSTN low mid-BUSY -> O_DUP_START=1 before reset; after reset all outputs 0, no VLD emitted, a fresh start proceeds normally.
